// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Multi-mode video test-pattern generator in the pixel-clock domain. Takes the
//   hdmi core's current pixel coordinate and produces a registered RGB colour one
//   cycle later. Mode, animation shift and frame count update only at frame start
//   (I_CX==0 && I_CY==0); the pixel at frame start still uses the old mode/shift.
//
//   Ports
//     I_CLK          pixel clock
//     I_RESET_N      synchronous active-low reset
//     I_CX, I_CY     current pixel column / line (CW bits)
//     I_MODE         requested pattern mode, sampled at frame start
//     I_SHIFT_STEP   per-frame animation increment
//     I_FREEZE       1 = hold the animation shift
//     O_R, O_G, O_B  pixel colour (BPC bits each)
//     O_MODE         mode currently applied
//     O_FRAME_CNT    frame starts seen since reset (wraps)
//
//   Build option: define PATTGEN_AUTOCYCLE_EN to make mode 7 an auto-cycle through
//   modes 0..6, AUTO_FRAMES frames each. Without it, mode 7 is solid black.
module video_pattern_gen #(
  parameter int H_ACTIVE     = 720,
  parameter int V_ACTIVE     = 480,
  parameter int CW           = 10,
  parameter int BPC          = 8,
  parameter int CHECKER_LOG2 = 5
`ifdef PATTGEN_AUTOCYCLE_EN
  ,
  parameter int AUTO_FRAMES  = 120
`endif
) (
  input  logic           I_CLK,
  input  logic           I_RESET_N,
  input  logic [CW-1:0]  I_CX,
  input  logic [CW-1:0]  I_CY,
  input  logic [2:0]     I_MODE,
  input  logic [BPC-1:0] I_SHIFT_STEP,
  input  logic           I_FREEZE,
  output logic [BPC-1:0] O_R,
  output logic [BPC-1:0] O_G,
  output logic [BPC-1:0] O_B,
  output logic [2:0]     O_MODE,
  output logic [15:0]    O_FRAME_CNT
);

  localparam logic [CW-1:0]   H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0]   V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0]   H_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]   V_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW+2:0]   H_DIV  = (CW+3)'(H_ACTIVE);

  logic [BPC-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic [2:0]     mode_q, mode_d;
  logic [BPC-1:0] shift_q, shift_d;
  logic [15:0]    fcnt_q, fcnt_d;

`ifdef PATTGEN_AUTOCYCLE_EN
  localparam int            ACW       = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_FRAMES - 1);

  // auto_on_q remembers that mode 7 was already requested at the previous
  // frame start, so a fresh entry restarts the cycle at mode 0.
  logic           auto_on_q, auto_on_d;
  logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
`endif

  logic           fs;
  logic           active, border, border_en, chk;
  logic [2:0]     bar_i;
  logic [BPC-1:0] cx_t, cy_t;

  assign fs   = (I_CX == '0) && (I_CY == '0);
  assign cx_t = I_CX[BPC-1:0];
  assign cy_t = I_CY[BPC-1:0];

  // Frame-synchronous state: mode, animation shift, frame counter.
  always_comb begin
    mode_d  = mode_q;
    shift_d = shift_q;
    fcnt_d  = fcnt_q;
`ifdef PATTGEN_AUTOCYCLE_EN
    auto_on_d  = auto_on_q;
    auto_cnt_d = auto_cnt_q;
`endif
    if (fs) begin
      if (!I_FREEZE) shift_d = shift_q + I_SHIFT_STEP;
      fcnt_d = fcnt_q + 16'd1;
`ifdef PATTGEN_AUTOCYCLE_EN
      if (I_MODE == 3'd7) begin
        auto_on_d = 1'b1;
        if (!auto_on_q) begin
          mode_d     = 3'd0;
          auto_cnt_d = '0;
        end else if (auto_cnt_q == AUTO_LAST) begin
          mode_d     = (mode_q == 3'd6) ? 3'd0 : mode_q + 3'd1;
          auto_cnt_d = '0;
        end else begin
          auto_cnt_d = auto_cnt_q + ACW'(1);
        end
      end else begin
        auto_on_d  = 1'b0;
        auto_cnt_d = '0;
        mode_d     = I_MODE;
      end
`else
      mode_d = I_MODE;
`endif
    end
  end

  // Pixel colour, computed from the mode/shift in force before any frame-start update.
  always_comb begin
    active    = (I_CX < H_ACT) && (I_CY < V_ACT);
    border    = (I_CX == '0) || (I_CY == '0) || (I_CX == H_LAST) || (I_CY == V_LAST);
    border_en = !((mode_q == 3'd3) || (mode_q == 3'd4) || (mode_q == 3'd7));
    bar_i     = 3'(({3'b000, I_CX} << 3) / H_DIV);
    chk       = I_CX[CHECKER_LOG2] ^ I_CY[CHECKER_LOG2] ^ shift_q[BPC-1];
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (mode_q)
      3'd0: begin
        r_d = cx_t + shift_q;
        g_d = cy_t + shift_q;
        b_d = cx_t + cy_t - shift_q;
      end
      3'd1: begin
        r_d = {BPC{~bar_i[1]}};
        g_d = {BPC{~bar_i[2]}};
        b_d = {BPC{~bar_i[0]}};
      end
      3'd2: begin
        r_d = {BPC{chk}};
        g_d = {BPC{chk}};
        b_d = {BPC{chk}};
      end
      3'd3: begin
        r_d = '1;
        g_d = '1;
        b_d = '1;
      end
      3'd5: begin
        r_d = cx_t + shift_q;
        g_d = cx_t + shift_q;
        b_d = cx_t + shift_q;
      end
      3'd6: begin
        r_d = cy_t + shift_q;
        g_d = cy_t + shift_q;
        b_d = cy_t + shift_q;
      end
      default: begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end
    endcase
    if (border && border_en) begin
      r_d = '1;
      g_d = '1;
      b_d = '1;
    end
    if (!active) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      shift_q <= '0;
      fcnt_q  <= '0;
`ifdef PATTGEN_AUTOCYCLE_EN
      auto_on_q  <= 1'b0;
      auto_cnt_q <= '0;
`endif
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      fcnt_q  <= fcnt_d;
`ifdef PATTGEN_AUTOCYCLE_EN
      auto_on_q  <= auto_on_d;
      auto_cnt_q <= auto_cnt_d;
`endif
    end
  end

  assign O_R         = r_q;
  assign O_G         = g_q;
  assign O_B         = b_q;
  assign O_MODE      = mode_q;
  assign O_FRAME_CNT = fcnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

  logic        I_CLK = 1'b0;
  logic        I_RESET_N;
  logic [9:0]  I_CX, I_CY;
  logic [2:0]  I_MODE;
  logic [7:0]  I_SHIFT_STEP;
  logic        I_FREEZE;
  logic [7:0]  O_R, O_G, O_B;
  logic [2:0]  O_MODE;
  logic [15:0] O_FRAME_CNT;

  int total = 0;
  int bad   = 0;

  always #5 I_CLK = ~I_CLK;

`ifdef PATTGEN_AUTOCYCLE_EN
  localparam int TB_AF = 2;
  video_pattern_gen #(.AUTO_FRAMES(TB_AF)) dut (
`else
  video_pattern_gen dut (
`endif
    .I_CLK(I_CLK), .I_RESET_N(I_RESET_N), .I_CX(I_CX), .I_CY(I_CY),
    .I_MODE(I_MODE), .I_SHIFT_STEP(I_SHIFT_STEP), .I_FREEZE(I_FREEZE),
    .O_R(O_R), .O_G(O_G), .O_B(O_B), .O_MODE(O_MODE), .O_FRAME_CNT(O_FRAME_CNT));

  // Reference model state
  int m_mode, m_shift, m_fcnt, m_auto_n;
  bit m_auto_on;
  logic [7:0]  exp_r, exp_g, exp_b;
  logic [2:0]  exp_mode;
  logic [15:0] exp_fcnt;
  int lcx, lcy;

  // Colour bar table W,Y,C,G,M,R,B,K as {R,G,B}
  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  function automatic void ref_pix(input int cx, input int cy, input int mode, input int sh,
                                  output int r, output int g, output int b);
    logic [2:0] c;
    int v;
    r = 0; g = 0; b = 0;
    if (cx >= 720 || cy >= 480) return;
    if ((cx == 0 || cy == 0 || cx == 719 || cy == 479) &&
        (mode == 0 || mode == 1 || mode == 2 || mode == 5 || mode == 6)) begin
      r = 255; g = 255; b = 255; return;
    end
    case (mode)
      0: begin r = (cx + sh) % 256; g = (cy + sh) % 256; b = (cx + cy - sh + 256) % 256; end
      1: begin
        c = bars[(cx * 8) / 720];
        r = c[2] ? 255 : 0; g = c[1] ? 255 : 0; b = c[0] ? 255 : 0;
      end
      2: begin
        v = (((cx / 32) + (cy / 32)) % 2) ^ ((sh >= 128) ? 1 : 0);
        r = v * 255; g = r; b = r;
      end
      3: begin r = 255; g = 255; b = 255; end
      5: begin r = (cx + sh) % 256; g = r; b = r; end
      6: begin r = (cy + sh) % 256; g = r; b = r; end
      default: begin r = 0; g = 0; b = 0; end
    endcase
  endfunction

  function automatic void frame_update();
    if (!I_FREEZE) m_shift = (m_shift + int'(I_SHIFT_STEP)) % 256;
    m_fcnt = (m_fcnt + 1) % 65536;
`ifdef PATTGEN_AUTOCYCLE_EN
    if (I_MODE == 3'd7) begin
      if (!m_auto_on) begin
        m_auto_on = 1; m_mode = 0; m_auto_n = 1;
      end else if (m_auto_n == TB_AF) begin
        m_mode = (m_mode + 1) % 7; m_auto_n = 1;
      end else begin
        m_auto_n++;
      end
    end else begin
      m_auto_on = 0; m_mode = int'(I_MODE);
    end
`else
    m_mode = int'(I_MODE);
`endif
  endfunction

  // Present one pixel, advance the model, and wait until the registered result is visible.
  task automatic pix(input int cx, input int cy);
    int r, g, b;
    @(negedge I_CLK);
    I_CX = cx[9:0];
    I_CY = cy[9:0];
    lcx = cx; lcy = cy;
    if (!I_RESET_N) begin
      m_mode = 0; m_shift = 0; m_fcnt = 0; m_auto_on = 0; m_auto_n = 0;
      r = 0; g = 0; b = 0;
    end else begin
      ref_pix(cx, cy, m_mode, m_shift, r, g, b);
      if (cx == 0 && cy == 0) frame_update();
    end
    exp_r = r[7:0]; exp_g = g[7:0]; exp_b = b[7:0];
    exp_mode = m_mode[2:0];
    exp_fcnt = m_fcnt[15:0];
    @(posedge I_CLK);
    #1;
  endtask

  function automatic int rnd_cx();
    return ($urandom_range(0, 7) == 0) ? 719 : int'($urandom_range(0, 1023));
  endfunction

  function automatic int rnd_cy();
    return ($urandom_range(0, 7) == 0) ? 479 : int'($urandom_range(1, 600));
  endfunction

  task automatic test_reset();
    I_RESET_N = 1'b1; I_MODE = 3'd2; I_SHIFT_STEP = 8'($urandom_range(1, 255)); I_FREEZE = 1'b0;
    pix(0, 0);
    for (int i = 0; i < 5; i++) pix(rnd_cx(), rnd_cy());
    I_RESET_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix(100 + i, 200);
      total++;
      if (O_R !== 8'd0 || O_G !== 8'd0 || O_B !== 8'd0 || O_MODE !== 3'd0 || O_FRAME_CNT !== 16'd0) begin
        bad++;
        $display("FAIL reset_state: got rgb=%h/%h/%h mode=%0d fcnt=%0d want 0/0/0 mode=0 fcnt=0",
                 O_R, O_G, O_B, O_MODE, O_FRAME_CNT);
      end
    end
    I_RESET_N = 1'b1; I_MODE = 3'd0;
    pix(1, 1);
    total++;
    if (O_R !== 8'd1 || O_G !== 8'd1 || O_B !== 8'd2 || O_MODE !== 3'd0) begin
      bad++;
      $display("FAIL reset_release: got rgb=%h/%h/%h mode=%0d want 01/01/02 mode=0", O_R, O_G, O_B, O_MODE);
    end
  endtask

  task automatic test_gradient();
    I_RESET_N = 1'b0; pix(3, 3); I_RESET_N = 1'b1;
    I_MODE = 3'd0; I_SHIFT_STEP = 8'd1; I_FREEZE = 1'b0;
    for (int f = 0; f < 3; f++) begin
      pix(0, 0);
      for (int i = 0; i < 10; i++) begin
        pix(rnd_cx(), rnd_cy());
        total++;
        if ({O_R, O_G, O_B} !== {exp_r, exp_g, exp_b} || O_MODE !== exp_mode) begin
          bad++;
          $display("FAIL gradient_pix (%0d,%0d): got %h/%h/%h m%0d want %h/%h/%h m%0d",
                   lcx, lcy, O_R, O_G, O_B, O_MODE, exp_r, exp_g, exp_b, exp_mode);
        end
      end
    end
    pix(10, 20);
    total++;
    if (O_R !== 8'd13 || O_G !== 8'd23 || O_B !== 8'd27 || O_FRAME_CNT !== 16'd3) begin
      bad++;
      $display("FAIL gradient_f3: got %0d/%0d/%0d fcnt=%0d want 13/23/27 fcnt=3", O_R, O_G, O_B, O_FRAME_CNT);
    end
    pix(719, 5);
    total++;
    if ({O_R, O_G, O_B} !== 24'hFFFFFF) begin
      bad++;
      $display("FAIL gradient_border: got %h/%h/%h want ff/ff/ff", O_R, O_G, O_B);
    end
    pix(730, 5);
    total++;
    if ({O_R, O_G, O_B} !== 24'h000000) begin
      bad++;
      $display("FAIL gradient_outside: got %h/%h/%h want 00/00/00", O_R, O_G, O_B);
    end
  endtask

  task automatic test_bars();
    I_MODE = 3'd1;
    pix(0, 0);
    pix(100, 50);
    total++;
    if ({O_R, O_G, O_B} !== 24'hFFFF00) begin
      bad++;
      $display("FAIL bars_yellow: got %h/%h/%h want ff/ff/00", O_R, O_G, O_B);
    end
    pix(650, 50);
    total++;
    if ({O_R, O_G, O_B} !== 24'h000000) begin
      bad++;
      $display("FAIL bars_black: got %h/%h/%h want 00/00/00", O_R, O_G, O_B);
    end
    pix(0, 50);
    total++;
    if ({O_R, O_G, O_B} !== 24'hFFFFFF) begin
      bad++;
      $display("FAIL bars_border: got %h/%h/%h want ff/ff/ff", O_R, O_G, O_B);
    end
    for (int i = 0; i < 16; i++) begin
      pix(i * 45 + 1, 100);
      total++;
      if ({O_R, O_G, O_B} !== {exp_r, exp_g, exp_b}) begin
        bad++;
        $display("FAIL bars_sweep (%0d,%0d): got %h/%h/%h want %h/%h/%h",
                 lcx, lcy, O_R, O_G, O_B, exp_r, exp_g, exp_b);
      end
    end
  endtask

  task automatic test_mode_switch();
    I_MODE = 3'd0; I_SHIFT_STEP = 8'($urandom_range(0, 255)); I_FREEZE = 1'b0;
    pix(0, 0);
    pix(50, 60);
    I_MODE = 3'd3;
    pix(300, 200);
    for (int i = 0; i < 8; i++) begin
      pix(rnd_cx(), rnd_cy());
      total++;
      if ({O_R, O_G, O_B} !== {exp_r, exp_g, exp_b} || O_MODE !== 3'd0) begin
        bad++;
        $display("FAIL switch_hold (%0d,%0d): got %h/%h/%h m%0d want %h/%h/%h m0",
                 lcx, lcy, O_R, O_G, O_B, O_MODE, exp_r, exp_g, exp_b);
      end
    end
    pix(0, 0);
    total++;
    if ({O_R, O_G, O_B} !== 24'hFFFFFF || O_MODE !== 3'd3) begin
      bad++;
      $display("FAIL switch_fs: got %h/%h/%h m%0d want ff/ff/ff m3", O_R, O_G, O_B, O_MODE);
    end
    pix(1, 1);
    total++;
    if ({O_R, O_G, O_B} !== 24'hFFFFFF) begin
      bad++;
      $display("FAIL switch_solid: got %h/%h/%h want ff/ff/ff", O_R, O_G, O_B);
    end
    I_MODE = 3'd4;
    pix(0, 0);
    I_MODE = 3'd0;
    pix(0, 0);
    total++;
    if ({O_R, O_G, O_B} !== 24'h000000 || O_MODE !== 3'd0) begin
      bad++;
      $display("FAIL switch_noborder: got %h/%h/%h m%0d want 00/00/00 m0", O_R, O_G, O_B, O_MODE);
    end
  endtask

  task automatic test_shift_wrap();
    I_RESET_N = 1'b0; pix(7, 7); I_RESET_N = 1'b1;
    I_MODE = 3'd0; I_SHIFT_STEP = 8'h80; I_FREEZE = 1'b0;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) I_FREEZE = 1'b1;
      pix(0, 0);
      pix(1, 1);
      total++;
      if (O_R !== ((f == 0) ? 8'h81 : 8'h01) || O_FRAME_CNT !== 16'(f + 1)) begin
        bad++;
        $display("FAIL shift_wrap f%0d: got r=%h fcnt=%0d want r=%h fcnt=%0d",
                 f, O_R, O_FRAME_CNT, (f == 0) ? 8'h81 : 8'h01, f + 1);
      end
    end
    I_FREEZE = 1'b0;
  endtask

  task automatic test_mode7();
`ifdef PATTGEN_AUTOCYCLE_EN
    I_RESET_N = 1'b0; pix(9, 9); I_RESET_N = 1'b1;
    I_MODE = 3'd7; I_SHIFT_STEP = 8'd3;
    for (int k = 0; k < 15; k++) begin
      pix(0, 0);
      total++;
      if (O_MODE !== 3'((k / 2) % 7)) begin
        bad++;
        $display("FAIL auto_seq k%0d: got mode=%0d want %0d", k, O_MODE, (k / 2) % 7);
      end
      pix(rnd_cx(), rnd_cy());
      total++;
      if ({O_R, O_G, O_B} !== {exp_r, exp_g, exp_b}) begin
        bad++;
        $display("FAIL auto_pix (%0d,%0d): got %h/%h/%h want %h/%h/%h",
                 lcx, lcy, O_R, O_G, O_B, exp_r, exp_g, exp_b);
      end
    end
    I_MODE = 3'd3;
    pix(0, 0);
    total++;
    if (O_MODE !== 3'd3) begin
      bad++;
      $display("FAIL auto_leave: got mode=%0d want 3", O_MODE);
    end
`else
    I_MODE = 3'd7;
    pix(0, 0);
    pix(1, 1);
    total++;
    if (O_MODE !== 3'd7 || {O_R, O_G, O_B} !== 24'h000000) begin
      bad++;
      $display("FAIL mode7_black: got %h/%h/%h m%0d want 00/00/00 m7", O_R, O_G, O_B, O_MODE);
    end
    pix(719, 5);
    total++;
    if ({O_R, O_G, O_B} !== 24'h000000) begin
      bad++;
      $display("FAIL mode7_noborder: got %h/%h/%h want 00/00/00", O_R, O_G, O_B);
    end
`endif
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      I_MODE = 3'($urandom_range(0, 7));
      I_SHIFT_STEP = 8'($urandom_range(0, 255));
      I_FREEZE = ($urandom_range(0, 3) == 0);
      pix(0, 0);
      total++;
      if ({O_R, O_G, O_B} !== {exp_r, exp_g, exp_b} || O_MODE !== exp_mode || O_FRAME_CNT !== exp_fcnt) begin
        bad++;
        $display("FAIL rand_fs f%0d: got %h/%h/%h m%0d c%0d want %h/%h/%h m%0d c%0d", f,
                 O_R, O_G, O_B, O_MODE, O_FRAME_CNT, exp_r, exp_g, exp_b, exp_mode, exp_fcnt);
      end
      for (int i = 0; i < 30; i++) begin
        if (i == 15) I_MODE = 3'($urandom_range(0, 7));
        pix(rnd_cx(), rnd_cy());
        total++;
        if ({O_R, O_G, O_B} !== {exp_r, exp_g, exp_b} || O_MODE !== exp_mode) begin
          bad++;
          $display("FAIL rand_pix (%0d,%0d): got %h/%h/%h m%0d want %h/%h/%h m%0d",
                   lcx, lcy, O_R, O_G, O_B, O_MODE, exp_r, exp_g, exp_b, exp_mode);
        end
      end
    end
  endtask

  initial begin
    I_RESET_N = 1'b0; I_CX = '0; I_CY = '0; I_MODE = '0; I_SHIFT_STEP = '0; I_FREEZE = 1'b0;
    m_mode = 0; m_shift = 0; m_fcnt = 0; m_auto_on = 0; m_auto_n = 0; lcx = 0; lcy = 0;
    pix(5, 5);
    pix(5, 5);
    test_reset();
    test_gradient();
    test_bars();
    test_mode_switch();
    test_shift_wrap();
    test_mode7();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
